// File: rtl/encounter_ctrl.sv
// encounter_ctrl
//   Overworld-to-battle sequencer. Turns held direction buttons into
//   frame-paced steps, rolls a random encounter on each grass step, runs a
//   16-frame fade, then requests a battle. Owns the player's persistent
//   health: healing in the overworld, latching the battle result, and
//   restoring it after a faint.
//
// Ports
//   clk_in                      pixel clock
//   rst_in                      asynchronous active-low reset
//   hcount_in, vcount_in        raster position; (0,0) marks a frame tick
//   left_in/right_in/up_in/down_in  level direction buttons
//   in_grass_in                 player stands on a grass tile
//   run_in                      battle-over pulse from the battle block
//   health_in                   battle block's health at the end of battle
//   start_out                   battle request level
//   health_out                  persistent player health
//   fade_out                    screen darkening level (0 none, 15 black)
//   step_out                    one-cycle pulse per completed step
//   state_out                   0 OVER, 1 FADE, 2 BATTLE, 3 FAINT
//
// Battle handshake: start_out is a level that rises when the fade completes
// and stays high until the battle block answers with a single-cycle run_in
// pulse; start_out drops the cycle after that pulse. run_in outside BATTLE
// is ignored, and a tick in the same cycle as run_in is ignored.
module encounter_ctrl #(
    parameter int STEP_FRAMES      = 8,
    parameter int ENCOUNTER_THRESH = 40,
    parameter int GRACE_STEPS      = 4,
    parameter int HEAL_FRAMES      = 60,
    parameter int FAINT_FRAMES     = 90,
    parameter int MAX_HEALTH       = 100
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        in_grass_in,
    input  logic        run_in,
    input  logic [7:0]  health_in,
    output logic        start_out,
    output logic [7:0]  health_out,
    output logic [3:0]  fade_out,
    output logic        step_out,
    output logic [1:0]  state_out
);

    localparam int SW = $clog2(STEP_FRAMES  > 1 ? STEP_FRAMES  : 2);
    localparam int HW = $clog2(HEAL_FRAMES  > 1 ? HEAL_FRAMES  : 2);
    localparam int FW = $clog2(FAINT_FRAMES > 1 ? FAINT_FRAMES : 2);
    localparam int GW = $clog2(GRACE_STEPS  > 0 ? GRACE_STEPS + 1 : 2);

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);
    localparam logic [HW-1:0] HEAL_LAST  = HW'(HEAL_FRAMES - 1);
    localparam logic [FW-1:0] FAINT_LAST = FW'(FAINT_FRAMES - 1);
    localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_STEPS);
    localparam logic [7:0]    HEALTH_MAX = 8'(MAX_HEALTH);
    // One extra bit so a threshold of 256 would still compare correctly.
    localparam logic [8:0]    THRESH9    = 9'(ENCOUNTER_THRESH);
    localparam logic [7:0]    LFSR_SEED  = 8'hA5;
    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0]    LFSR_MASK  = 8'hB8;

    typedef enum logic [1:0] {
        S_OVER   = 2'd0,
        S_FADE   = 2'd1,
        S_BATTLE = 2'd2,
        S_FAINT  = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic [SW-1:0] step_cnt_q,  step_cnt_d;
    logic [HW-1:0] heal_cnt_q,  heal_cnt_d;
    logic [FW-1:0] faint_cnt_q, faint_cnt_d;
    logic [3:0]    fade_cnt_q,  fade_cnt_d;
    logic [GW-1:0] grace_q,     grace_d;
    logic [7:0]    lfsr_q,      lfsr_d;
    logic          start_q,     start_d;
    logic [7:0]    health_q,    health_d;
    logic [3:0]    fade_q,      fade_d;
    logic          step_q,      step_d;

    logic tick;
    logic any_dir;

    assign tick    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign any_dir = left_in | right_in | up_in | down_in;

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        heal_cnt_d  = heal_cnt_q;
        faint_cnt_d = faint_cnt_q;
        fade_cnt_d  = fade_cnt_q;
        grace_d     = grace_q;
        start_d     = start_q;
        health_d    = health_q;
        fade_d      = fade_q;
        step_d      = 1'b0;
        lfsr_d      = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_MASK : 8'h00);

        case (state_q)
            S_OVER: begin
                if (tick) begin
                    if (any_dir) begin
                        if (step_cnt_q == STEP_LAST) begin
                            step_cnt_d = '0;
                            step_d     = 1'b1;
                            grace_d    = (grace_q == '0) ? '0 : grace_q - 1'b1;
                            // The roll uses grace before this step's decrement.
                            if (in_grass_in && (grace_q == '0) &&
                                ({1'b0, lfsr_q} < THRESH9)) begin
                                fade_cnt_d = 4'd0;
                                fade_d     = 4'd0;
                                state_d    = S_FADE;
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end else begin
                        // Releasing all buttons forfeits the partial step.
                        step_cnt_d = '0;
                    end

                    if (heal_cnt_q == HEAL_LAST) begin
                        heal_cnt_d = '0;
                        health_d   = (health_q >= HEALTH_MAX) ? HEALTH_MAX
                                                              : health_q + 8'd1;
                    end else begin
                        heal_cnt_d = heal_cnt_q + 1'b1;
                    end
                end
            end

            S_FADE: begin
                if (tick) begin
                    if (fade_cnt_q == 4'd15) begin
                        state_d = S_BATTLE;
                        start_d = 1'b1;
                        fade_d  = 4'd0;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 4'd1;
                        fade_d     = fade_cnt_q + 4'd1;
                    end
                end
            end

            S_BATTLE: begin
                if (run_in) begin
                    start_d = 1'b0;
                    grace_d = GRACE_INIT;
                    if (health_in == 8'd0) begin
                        state_d     = S_FAINT;
                        fade_d      = 4'd15;
                        faint_cnt_d = '0;
                    end else begin
                        state_d    = S_OVER;
                        health_d   = (health_in > HEALTH_MAX) ? HEALTH_MAX : health_in;
                        heal_cnt_d = '0;
                        step_cnt_d = '0;
                    end
                end
            end

            S_FAINT: begin
                if (tick) begin
                    if (faint_cnt_q == FAINT_LAST) begin
                        state_d  = S_OVER;
                        health_d = HEALTH_MAX;
                        fade_d   = 4'd0;
                    end else begin
                        faint_cnt_d = faint_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_OVER;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_OVER;
            step_cnt_q  <= '0;
            heal_cnt_q  <= '0;
            faint_cnt_q <= '0;
            fade_cnt_q  <= 4'd0;
            grace_q     <= GRACE_INIT;
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            health_q    <= HEALTH_MAX;
            fade_q      <= 4'd0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            heal_cnt_q  <= heal_cnt_d;
            faint_cnt_q <= faint_cnt_d;
            fade_cnt_q  <= fade_cnt_d;
            grace_q     <= grace_d;
            lfsr_q      <= lfsr_d;
            start_q     <= start_d;
            health_q    <= health_d;
            fade_q      <= fade_d;
            step_q      <= step_d;
        end
    end

    assign start_out  = start_q;
    assign health_out = health_q;
    assign fade_out   = fade_q;
    assign step_out   = step_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_encounter_ctrl.sv
module tb_encounter_ctrl;

    localparam int THRESH = 255;
    localparam int GRACE  = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        left_b, right_b, up_b, down_b;
    logic        in_grass;
    logic        run;
    logic [7:0]  health_in;
    logic        start_out;
    logic [7:0]  health_out;
    logic [3:0]  fade_out;
    logic        step_out;
    logic [1:0]  state_out;

    int vectors     = 0;
    int miscompares = 0;
    int g           = GRACE;   // bench's own grace count
    logic [7:0] m_lfsr;        // reference LFSR

    always #5 clk = ~clk;

    encounter_ctrl #(
        .STEP_FRAMES(8), .ENCOUNTER_THRESH(THRESH), .GRACE_STEPS(GRACE),
        .HEAL_FRAMES(60), .FAINT_FRAMES(90), .MAX_HEALTH(100)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .left_in(left_b), .right_in(right_b), .up_in(up_b), .down_in(down_b),
        .in_grass_in(in_grass), .run_in(run), .health_in(health_in),
        .start_out(start_out), .health_out(health_out), .fade_out(fade_out),
        .step_out(step_out), .state_out(state_out)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        hcount = 11'd5; vcount = 10'd5;
        left_b = 0; right_b = 0; up_b = 0; down_b = 0;
        in_grass = 0; run = 0; health_in = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        g = GRACE;
    endtask

    // One tick cycle followed by one idle cycle; returns at the negedge
    // after the tick edge with l = LFSR value seen during the tick cycle.
    task automatic tick_once(output logic [7:0] l);
        @(negedge clk);
        hcount = 11'd0; vcount = 10'd0;
        l = m_lfsr;
        @(negedge clk);
        hcount = 11'd5; vcount = 10'd5;
    endtask

    task automatic idle_ticks(input int n);
        logic [7:0] l;
        for (int i = 0; i < n; i++) tick_once(l);
    endtask

    task automatic pulse_run(input logic [7:0] h, input logic with_tick);
        @(negedge clk);
        run = 1'b1; health_in = h;
        if (with_tick) begin hcount = 11'd0; vcount = 10'd0; end
        @(negedge clk);
        run = 1'b0; hcount = 11'd5; vcount = 10'd5;
    endtask

    // Walk in grass until an encounter, then run stop_fade fade ticks.
    task automatic go_to_battle(input int stop_fade);
        logic [7:0] l;
        logic enc;
        int steps;
        enc = 1'b0; steps = 0;
        in_grass = 1'b1; up_b = 1'b1;
        while (!enc && steps < 12) begin
            for (int t = 0; t < 8; t++) tick_once(l);
            enc = (g == 0) && (l < 8'(THRESH));
            if (g > 0) g = g - 1;
            steps++;
            vectors++;
            if (step_out !== 1'b1) begin
                miscompares++;
                $display("FAIL walk_step_pulse step %0d: got %0d expected 1", steps, step_out);
            end
            vectors++;
            if (state_out !== (enc ? 2'd1 : 2'd0)) begin
                miscompares++;
                $display("FAIL walk_encounter step %0d: got state %0d expected %0d", steps, state_out, enc ? 1 : 0);
            end
        end
        in_grass = 1'b0; up_b = 1'b0;
        vectors++;
        if (!enc || fade_out !== 4'd0) begin
            miscompares++;
            $display("FAIL encounter_entry: enc %0d fade %0d expected enc 1 fade 0", enc, fade_out);
        end
        for (int j = 1; j <= 16 && j <= stop_fade; j++) begin
            tick_once(l);
            if (j < 16) begin
                vectors++;
                if (fade_out !== 4'(j) || state_out !== 2'd1 || start_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fade_ramp tick %0d: got fade %0d state %0d start %0d expected fade %0d state 1 start 0",
                             j, fade_out, state_out, start_out, j);
                end
            end else begin
                vectors++;
                if (state_out !== 2'd2 || start_out !== 1'b1 || fade_out !== 4'd0) begin
                    miscompares++;
                    $display("FAIL battle_entry: got state %0d start %0d fade %0d expected 2 1 0",
                             state_out, start_out, fade_out);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (start_out !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %0d expected 0", start_out); end
        vectors++; if (health_out !== 8'd100) begin miscompares++; $display("FAIL reset_health: got %0d expected 100", health_out); end
        vectors++; if (fade_out !== 4'd0) begin miscompares++; $display("FAIL reset_fade: got %0d expected 0", fade_out); end
        vectors++; if (step_out !== 1'b0) begin miscompares++; $display("FAIL reset_step: got %0d expected 0", step_out); end
        vectors++; if (state_out !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_steps();
        logic [7:0] l;
        int pulses, bad_pos;
        pulses = 0; bad_pos = 0;
        right_b = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick_once(l);
            if (step_out === 1'b1) pulses++;
            if (step_out !== ((i % 8) == 7)) bad_pos++;
            if ((i % 8) == 7) begin
                @(negedge clk);
                if (step_out !== 1'b0) bad_pos++;
            end
        end
        right_b = 1'b0;
        g = 0;
        vectors++; if (pulses !== 10) begin miscompares++; $display("FAIL steps_count: got %0d expected 10", pulses); end
        vectors++; if (bad_pos !== 0) begin miscompares++; $display("FAIL steps_timing: got %0d misplaced expected 0", bad_pos); end
        vectors++; if (state_out !== 2'd0) begin miscompares++; $display("FAIL steps_state: got %0d expected 0", state_out); end
        vectors++; if (health_out !== 8'd100) begin miscompares++; $display("FAIL steps_health: got %0d expected 100", health_out); end
    endtask

    task automatic test_encounter();
        do_reset();
        go_to_battle(16);
    endtask

    task automatic test_battle_return();
        // run_in coincident with a tick: only the return happens
        pulse_run(8'd70, 1'b1);
        g = GRACE;
        vectors++; if (start_out !== 1'b0) begin miscompares++; $display("FAIL return_start: got %0d expected 0", start_out); end
        vectors++; if (health_out !== 8'd70) begin miscompares++; $display("FAIL return_health: got %0d expected 70", health_out); end
        vectors++; if (state_out !== 2'd0) begin miscompares++; $display("FAIL return_state: got %0d expected 0", state_out); end
        idle_ticks(59);
        vectors++; if (health_out !== 8'd70) begin miscompares++; $display("FAIL heal_early: got %0d expected 70", health_out); end
        idle_ticks(1);
        vectors++; if (health_out !== 8'd71) begin miscompares++; $display("FAIL heal_one: got %0d expected 71", health_out); end
    endtask

    task automatic test_faint();
        go_to_battle(16);
        pulse_run(8'd0, 1'b0);
        g = GRACE;
        vectors++;
        if (state_out !== 2'd3 || fade_out !== 4'd15 || start_out !== 1'b0) begin
            miscompares++;
            $display("FAIL faint_entry: got state %0d fade %0d start %0d expected 3 15 0", state_out, fade_out, start_out);
        end
        idle_ticks(89);
        vectors++;
        if (state_out !== 2'd3 || fade_out !== 4'd15) begin
            miscompares++;
            $display("FAIL faint_hold: got state %0d fade %0d expected 3 15", state_out, fade_out);
        end
        idle_ticks(1);
        vectors++;
        if (state_out !== 2'd0 || fade_out !== 4'd0 || health_out !== 8'd100) begin
            miscompares++;
            $display("FAIL faint_restore: got state %0d fade %0d health %0d expected 0 0 100", state_out, fade_out, health_out);
        end
    endtask

    task automatic test_saturate();
        go_to_battle(16);
        pulse_run(8'd150, 1'b0);
        g = GRACE;
        vectors++; if (health_out !== 8'd100) begin miscompares++; $display("FAIL clamp_health: got %0d expected 100", health_out); end
        go_to_battle(16);
        pulse_run(8'd99, 1'b0);
        g = GRACE;
        vectors++; if (health_out !== 8'd99) begin miscompares++; $display("FAIL latch_99: got %0d expected 99", health_out); end
        idle_ticks(60);
        vectors++; if (health_out !== 8'd100) begin miscompares++; $display("FAIL heal_to_max: got %0d expected 100", health_out); end
        idle_ticks(60);
        vectors++; if (health_out !== 8'd100) begin miscompares++; $display("FAIL heal_saturate: got %0d expected 100", health_out); end
    endtask

    task automatic test_partial_step();
        logic [7:0] l;
        int pulses, bad_pos;
        pulses = 0; bad_pos = 0;
        left_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_once(l);
            if (step_out !== 1'b0) bad_pos++;
        end
        left_b = 1'b0;
        tick_once(l);
        if (step_out !== 1'b0) bad_pos++;
        left_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick_once(l);
            if (step_out === 1'b1) pulses++;
            if (step_out !== (i == 7)) bad_pos++;
        end
        left_b = 1'b0;
        if (g > 0) g = g - 1;
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL partial_count: got %0d expected 1", pulses); end
        vectors++; if (bad_pos !== 0) begin miscompares++; $display("FAIL partial_timing: got %0d misplaced expected 0", bad_pos); end
        // run_in in OVER is ignored
        pulse_run(8'd5, 1'b0);
        vectors++;
        if (state_out !== 2'd0 || start_out !== 1'b0 || health_out !== 8'd100) begin
            miscompares++;
            $display("FAIL run_in_over: got state %0d start %0d health %0d expected 0 0 100", state_out, start_out, health_out);
        end
    endtask

    task automatic test_reset_mid();
        // mid-fade reset, checked before any clock edge
        go_to_battle(7);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (state_out !== 2'd0 || fade_out !== 4'd0 || start_out !== 1'b0 ||
            health_out !== 8'd100 || step_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_fade: got state %0d fade %0d start %0d health %0d step %0d expected 0 0 0 100 0",
                     state_out, fade_out, start_out, health_out, step_out);
        end
        @(negedge clk); rst_n = 1'b1; g = GRACE;
        // mid-battle reset with reduced health
        go_to_battle(16);
        pulse_run(8'd50, 1'b0);
        g = GRACE;
        vectors++; if (health_out !== 8'd50) begin miscompares++; $display("FAIL latch_50: got %0d expected 50", health_out); end
        go_to_battle(16);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (state_out !== 2'd0 || start_out !== 1'b0 || health_out !== 8'd100 || fade_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_battle: got state %0d start %0d health %0d fade %0d expected 0 0 100 0",
                     state_out, start_out, health_out, fade_out);
        end
        @(negedge clk); rst_n = 1'b1; g = GRACE;
        // encounter timing after reset follows the LFSR restarted from A5
        go_to_battle(16);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_n = 1'b1;
        set_idle();
        test_reset();
        test_steps();
        test_encounter();
        test_battle_return();
        test_faint();
        test_saturate();
        test_partial_step();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/encounter_ctrl.md
# encounter_ctrl

Overworld-to-battle sequencer sitting directly upstream of the battle screen. It converts held direction buttons into frame-paced steps and rolls a random encounter on each step taken in grass. It runs a fade-in transition and then holds the battle block's `start` high until that block pulses `run`. It also owns the player's persistent health: it feeds the health into battle, latches the result afterward, heals slowly in the overworld, and restores the player after a faint.

## Interface
- STEP_FRAMES, 8: frames a direction must be held per step
- ENCOUNTER_THRESH, 40: encounter fires when 8-bit LFSR value < this
- GRACE_STEPS, 4: steps after reset or after a battle during which no encounter can fire
- HEAL_FRAMES, 60: overworld frames per +1 health
- FAINT_FRAMES, 90: frames held black after a faint
- MAX_HEALTH, 100: health ceiling and restore value
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal pixel index
- vcount_in  in  10  vertical pixel index
- left_in, right_in, up_in, down_in  in  1 each  level direction buttons
- in_grass_in  in  1  player currently on a grass tile
- run_in  in  1  battle-over pulse from battle block
- health_in  in  8  battle block's current health output
- start_out  out  1  level to battle block's `start`
- health_out  out  8  persistent player health, to battle block's `health_in`
- fade_out  out  4  darkening level for display mux (0 none, 15 black)
- step_out  out  1  one-cycle pulse per completed step
- state_out  out  2  0 OVER, 1 FADE, 2 BATTLE, 3 FAINT

## Operation
- A frame tick (`tick`) is any cycle where hcount_in==0 and vcount_in==0. All counters advance only on tick, except the LFSR and the run_in handling.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every clock. The encounter roll samples the LFSR value in the tick cycle.
- OVER:
  - On tick with any direction held, step_cnt increments.
  - When step_cnt == STEP_FRAMES-1: step_cnt←0 and step_out pulses. grace decrements, saturating at 0.
  - An encounter fires on that step if in_grass_in=1, grace (its value before the decrement) ==0, and lfsr < ENCOUNTER_THRESH. An encounter sets fade_cnt←0 and moves to FADE.
  - On tick with no direction held, step_cnt←0.
  - heal_cnt counts ticks. At HEAL_FRAMES-1: heal_cnt←0 and health_out←min(health_out+1, MAX_HEALTH).
- FADE: fade_out=fade_cnt. Each tick increments fade_cnt. The tick at fade_cnt==15 moves to BATTLE, sets start_out←1 and fade_out←0. Buttons and healing are ignored.
- BATTLE: start_out held 1. On run_in=1:
  - start_out←0 and grace←GRACE_STEPS.
  - If health_in==0: go to FAINT with fade_out←15 and faint_cnt←0.
  - Otherwise: health_out←min(health_in, MAX_HEALTH), heal_cnt←0, step_cnt←0, and go to OVER.
- FAINT: fade_out=15. Each tick increments faint_cnt. The tick at FAINT_FRAMES-1 sets health_out←MAX_HEALTH, fade_out←0, and moves to OVER.
- Arithmetic: health 8-bit unsigned, never exceeds MAX_HEALTH, never wraps. Counters are sized for their parameters.

## Timing
- Reset values: state OVER, start_out 0, health_out MAX_HEALTH, fade_out 0, step_out 0, state_out 0, grace GRACE_STEPS, all counters 0, LFSR 8'hA5.
- All outputs are registered. Each changes the cycle after the tick or run_in cycle that causes it.
- step_out is exactly one clock wide.
- Encounter to start_out: exactly 16 ticks plus 1 clock after the encounter step's tick.
- run_in while not in BATTLE: ignored. run_in coincident with tick in BATTLE: run_in handled, nothing else happens.
- Direction released mid-step: progress lost, no step_out.
- An encounter step still pulses step_out.
- Reset asserted in any state, including mid-fade or in battle: immediate return to reset values. start_out drops asynchronously.

## Test plan
- Reset, in_grass_in=0, right_in held 80 ticks (STEP_FRAMES=8) -> 10 step_out pulses, state stays OVER, health_out=100.
- ENCOUNTER_THRESH=255, GRACE_STEPS=2, grass, hold up_in -> no encounter on steps 1-2; step 3 enters FADE; fade_out ramps 0..15 over 16 ticks; start_out=1, fade_out=0.
- In BATTLE, health_in=70, pulse run_in -> start_out=0 next clock, health_out=70, state OVER. After 60 ticks health_out=71. Heals saturate at 100.
- In BATTLE, health_in=0, pulse run_in -> FAINT with fade_out=15 for 90 ticks, then health_out=100, fade_out=0, state OVER.
- Hold left_in 5 ticks, release, hold 8 ticks -> exactly one step_out, on the 8th tick of the second hold. run_in pulsed during OVER -> no effect.
- Drive rst_in low mid-FADE (fade_out=7) and mid-BATTLE -> all outputs return to reset values without waiting for clk_in. LFSR sequence restarts from A5.
